number_converter_seq: RTL and testbench

- Registered converter from four 10-bit binary operands to packed 3-digit BCD, for the 24-game display and digit path.
- Sits between the operand/number-entry logic and the 7-segment/digit-select logic.
- Each lane converts independently; a per-lane valid bit blanks unused lanes.

---
 rtl/number_converter_seq.sv | 68 ++++++
 tb/tb_number_converter_seq.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/number_converter_seq.sv
// Four-lane registered binary-to-BCD converter with saturation at 999 and per-lane blanking.
// Optional macro LEADING_ZERO_BLANK_EN replaces leading zero digits of valid lanes with 4'hF.
module number_converter_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  num1,
  input  logic [9:0]  num2,
  input  logic [9:0]  num3,
  input  logic [9:0]  num4,
  input  logic [3:0]  valid,
  output logic [47:0] numbers
);

  localparam int          LANES     = 4;
  localparam int          DIGITS    = 3;
  localparam int          LANE_W    = DIGITS * 4;
  localparam logic [9:0]  MAX_VAL   = 10'd999;
  localparam logic [3:0]  BLANK_DIG = 4'hF;

  logic [9:0]         lane_num [LANES];
  logic [LANES*LANE_W-1:0] numbers_d, numbers_q;

  // Shift-add-3 over all ten input bits; the caller guarantees the value is at most 999.
  function automatic logic [LANE_W-1:0] bin2bcd(input logic [9:0] bin);
    logic [LANE_W+9:0] sh;
    sh = {{LANE_W{1'b0}}, bin};
    for (int i = 0; i < 10; i++) begin
      if (sh[13:10] >= 4'd5) sh[13:10] = sh[13:10] + 4'd3;
      if (sh[17:14] >= 4'd5) sh[17:14] = sh[17:14] + 4'd3;
      if (sh[21:18] >= 4'd5) sh[21:18] = sh[21:18] + 4'd3;
      sh = sh << 1;
    end
    return sh[LANE_W+9:10];
  endfunction

  assign lane_num[0] = num1;
  assign lane_num[1] = num2;
  assign lane_num[2] = num3;
  assign lane_num[3] = num4;

  always_comb begin
    logic [9:0]        sat;
    logic [LANE_W-1:0] code;
    numbers_d = '0;
    sat       = '0;
    code      = '0;
    for (int l = 0; l < LANES; l++) begin
      sat  = (lane_num[l] > MAX_VAL) ? MAX_VAL : lane_num[l];
      code = bin2bcd(sat);
`ifdef LEADING_ZERO_BLANK_EN
      // Tens only blanks when hundreds was also zero, so test before overwriting hundreds.
      if (code[11:8] == 4'd0 && code[7:4] == 4'd0) code[7:4] = BLANK_DIG;
      if (code[11:8] == 4'd0) code[11:8] = BLANK_DIG;
`endif
      if (!valid[l]) code = {DIGITS{BLANK_DIG}};
      // Lane 1 occupies the most significant slice.
      numbers_d[(LANES-1-l)*LANE_W +: LANE_W] = code;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) numbers_q <= '0;
    else        numbers_q <= numbers_d;
  end

  assign numbers = numbers_q;

endmodule

// File: tb/tb_number_converter_seq.sv
// Self-checking bench for number_converter_seq: fixed vector table, multi-cycle
// corner sequences and randomized traffic against a decimal-arithmetic reference model.
module tb_number_converter_seq;

  logic        clk;
  logic        rst_n;
  logic [9:0]  num1, num2, num3, num4;
  logic [3:0]  valid;
  logic [47:0] numbers;

  int vectors;
  int miscompares;

  typedef struct {
    string       name;
    logic [9:0]  n1, n2, n3, n4;
    logic [3:0]  v;
    logic [47:0] exp;
  } vec_t;

  vec_t vecs [6];

  number_converter_seq dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .num1    (num1),
    .num2    (num2),
    .num3    (num3),
    .num4    (num4),
    .valid   (valid),
    .numbers (numbers)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: decimal digits by division, then blanking rules.
  function automatic logic [11:0] refLane(input int value, input bit v);
    int val, h, t, o;
    logic [11:0] r;
    if (!v) return 12'hFFF;
    val = (value > 999) ? 999 : value;
    h = val / 100;
    t = (val / 10) % 10;
    o = val % 10;
    r = {h[3:0], t[3:0], o[3:0]};
`ifdef LEADING_ZERO_BLANK_EN
    if (h == 0) r[11:8] = 4'hF;
    if (h == 0 && t == 0) r[7:4] = 4'hF;
`endif
    return r;
  endfunction

  function automatic logic [47:0] refNumbers(input int a, input int b, input int c,
                                             input int d, input logic [3:0] v);
    return {refLane(a, v[0]), refLane(b, v[1]), refLane(c, v[2]), refLane(d, v[3])};
  endfunction

  task automatic setVec(input int i, input string nm, input logic [9:0] a, input logic [9:0] b,
                        input logic [9:0] c, input logic [9:0] d, input logic [3:0] v,
                        input logic [47:0] e);
    vecs[i].name = nm;
    vecs[i].n1 = a; vecs[i].n2 = b; vecs[i].n3 = c; vecs[i].n4 = d;
    vecs[i].v = v;
    vecs[i].exp = e;
  endtask

  task automatic driveInputs(input logic [9:0] a, input logic [9:0] b, input logic [9:0] c,
                             input logic [9:0] d, input logic [3:0] v);
    num1 = a; num2 = b; num3 = c; num4 = d; valid = v;
  endtask

  // Drive inputs, let one rising edge capture them, sample 1 time unit later.
  task automatic applyStimulus(input logic [9:0] a, input logic [9:0] b, input logic [9:0] c,
                               input logic [9:0] d, input logic [3:0] v);
    driveInputs(a, b, c, d, v);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string nm, input logic [47:0] got, input logic [47:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  initial begin
    logic [9:0]  r1, r2, r3, r4;
    logic [3:0]  rv;
    logic [9:0]  cur2;
    logic [11:0] prev2;

    vectors = 0;
    miscompares = 0;

`ifdef LEADING_ZERO_BLANK_EN
    setVec(0, "boundary",   10'd0,   10'd999, 10'd1000, 10'd1023, 4'hF,    48'hFF0_999_999_999);
    setVec(1, "blank_0101", 10'd7,   10'd8,   10'd9,    10'd10,   4'b0101, 48'hFF7_FFF_FF9_FFF);
    setVec(2, "lead_zero",  10'd14,  10'd5,   10'd0,    10'd105,  4'hF,    48'hF14_FF5_FF0_105);
    setVec(3, "mixed",      10'd123, 10'd456, 10'd189,  10'd14,   4'hF,    48'h123_456_189_F14);
    setVec(4, "all_blank",  10'd321, 10'd654, 10'd987,  10'd1,    4'h0,    48'hFFF_FFF_FFF_FFF);
    setVec(5, "blank_1110", 10'd512, 10'd1,   10'd99,   10'd100,  4'b1110, 48'hFFF_FF1_F99_100);
`else
    setVec(0, "boundary",   10'd0,   10'd999, 10'd1000, 10'd1023, 4'hF,    48'h000_999_999_999);
    setVec(1, "blank_0101", 10'd7,   10'd8,   10'd9,    10'd10,   4'b0101, 48'h007_FFF_009_FFF);
    setVec(2, "lead_zero",  10'd14,  10'd5,   10'd0,    10'd105,  4'hF,    48'h014_005_000_105);
    setVec(3, "mixed",      10'd123, 10'd456, 10'd189,  10'd14,   4'hF,    48'h123_456_189_014);
    setVec(4, "all_blank",  10'd321, 10'd654, 10'd987,  10'd1,    4'h0,    48'hFFF_FFF_FFF_FFF);
    setVec(5, "blank_1110", 10'd512, 10'd1,   10'd99,   10'd100,  4'b1110, 48'hFFF_001_099_100);
`endif

    // Reset held with live inputs: output stays zero across edges.
    rst_n = 1'b0;
    driveInputs(10'd123, 10'd0, 10'd0, 10'd0, 4'hF);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_hold", numbers, 48'h0);

    // Release mid-cycle; the very next edge registers the current inputs.
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("reset_release", numbers, refNumbers(123, 0, 0, 0, 4'hF));

    // Sequential load, one lane changing per cycle.
    applyStimulus(10'd0, 10'd0, 10'd0, 10'd0, 4'hF);
    checkOutput("seq_zero", numbers, refNumbers(0, 0, 0, 0, 4'hF));
    applyStimulus(10'd123, 10'd0, 10'd0, 10'd0, 4'hF);
    checkOutput("seq_n1", numbers, refNumbers(123, 0, 0, 0, 4'hF));
    applyStimulus(10'd123, 10'd456, 10'd0, 10'd0, 4'hF);
    checkOutput("seq_n2", numbers, refNumbers(123, 456, 0, 0, 4'hF));
    applyStimulus(10'd123, 10'd456, 10'd189, 10'd0, 4'hF);
    checkOutput("seq_n3", numbers, refNumbers(123, 456, 189, 0, 4'hF));
    driveInputs(10'd123, 10'd456, 10'd189, 10'd14, 4'hF);
    #2;
    checkOutput("seq_n4_before_edge", numbers, refNumbers(123, 456, 189, 0, 4'hF));
    @(posedge clk);
    #1;
`ifdef LEADING_ZERO_BLANK_EN
    checkOutput("seq_n4", numbers, 48'h123_456_189_F14);
`else
    checkOutput("seq_n4", numbers, 48'h123_456_189_014);
`endif

    // Asynchronous reset mid-cycle clears output without an edge.
    #3 rst_n = 1'b0;
    #1;
    checkOutput("async_reset", numbers, 48'h0);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("async_release", numbers, refNumbers(123, 456, 189, 14, 4'hF));

    // Table-driven vectors.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].n1, vecs[i].n2, vecs[i].n3, vecs[i].n4, vecs[i].v);
      checkOutput(vecs[i].name, numbers, vecs[i].exp);
    end

    // Latency: lane 2 toggles each cycle and must lag by exactly one edge.
    applyStimulus(10'd0, 10'd1, 10'd0, 10'd0, 4'hF);
    prev2 = refLane(1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      cur2 = (i % 2 == 0) ? 10'd512 : 10'd1;
      driveInputs(10'd0, cur2, 10'd0, 10'd0, 4'hF);
      #2;
      checkOutput("latency_hold", {36'h0, numbers[35:24]}, {36'h0, prev2});
      @(posedge clk);
      #1;
      prev2 = refLane(int'(cur2), 1'b1);
      checkOutput("latency_update", {36'h0, numbers[35:24]}, {36'h0, prev2});
    end

    // Randomized traffic, biased toward the saturation region now and then.
    for (int i = 0; i < 200; i++) begin
      r1 = 10'($urandom);
      r2 = 10'($urandom);
      r3 = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(990, 1023)) : 10'($urandom);
      r4 = 10'($urandom_range(0, 20));
      rv = 4'($urandom);
      applyStimulus(r1, r2, r3, r4, rv);
      checkOutput("random", numbers, refNumbers(int'(r1), int'(r2), int'(r3), int'(r4), rv));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
